// File: rtl/sysarr_pkg.sv
// Shared definitions for the systolic-array output path.
//   DEF_*      : default geometry of the array and its collector
//   psum_t     : one signed partial sum at the default width
//   psum_row_t : one full row (all lanes) at the default geometry
//   psum_lane  : extract lane k from a default-geometry row vector
//   clog2_int  : ceiling log2, used to size FIFO pointers
package sysarr_pkg;

  localparam int DEF_ARRAY_N    = 8;
  localparam int DEF_PSUM_BW    = 19;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_BW     = 16;

  typedef logic [DEF_PSUM_BW-1:0]             psum_t;
  typedef logic [DEF_ARRAY_N*DEF_PSUM_BW-1:0] psum_row_t;

  // Lane k occupies bits [k*BW +: BW]; lane 0 is the least significant.
  function automatic psum_t psum_lane(input psum_row_t vec, input int k);
    return vec[k*DEF_PSUM_BW +: DEF_PSUM_BW];
  endfunction

  function automatic int clog2_int(input int v);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_row_fifo.sv
// Synchronous show-ahead FIFO holding aligned psum rows.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous flush (pointers and count to zero)
//   wr_en     : push request with wr_data
//   rd_en     : pop request; rd_data always shows the head entry
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : current occupancy
//   drop      : a push was refused this cycle (full and no pop)
// A push into a full FIFO is accepted when a pop happens in the same cycle,
// so a full FIFO that is being drained never loses a row.
module psum_row_fifo
  import sysarr_pkg::*;
#(
  parameter int WIDTH = DEF_ARRAY_N * DEF_PSUM_BW,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int CW    = clog2_int(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             drop
);

  localparam int            AW       = CW - 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  assign do_pop  = rd_en && !empty && !clear;
  assign do_push = wr_en && !clear && (!full || do_pop);
  assign drop    = wr_en && !clear && full && !do_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/psum_deskew_collector.sv
// Collects the diagonally skewed psum wavefront leaving the bottom of the
// systolic array, realigns each row and buffers it for a downstream consumer.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous flush of FIFO, in-flight rows, row_cnt, ovf_err
//   in_valid  : lane 0 of a new row is on psum_in this cycle
//   psum_in   : skewed lanes; lane k of a row arrives k cycles after lane 0
//   out_valid : an aligned row is available on out_data
//   out_ready : consumer accepts the row
//   out_data  : aligned row (head of FIFO), all-zero when out_valid is low
//   row_cnt   : rows handed off, wrapping
//   ovf_err   : sticky, set when a row was dropped because the FIFO was full
//
// Handshake: a row transfers on every cycle where out_valid && out_ready.
// Once out_valid is high it stays high and out_data stays constant until that
// transfer happens (only clear or rst can withdraw it). out_valid does not
// depend on out_ready. The array side has no ready: it cannot stall, so a row
// arriving at a full FIFO is dropped and flagged instead of back-pressured.
module psum_deskew_collector
  import sysarr_pkg::*;
#(
  parameter int ARRAY_N        = DEF_ARRAY_N,
  parameter int PARTIAL_SUM_BW = DEF_PSUM_BW,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int CNT_BW         = DEF_CNT_BW
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                in_valid,
  input  logic [ARRAY_N*PARTIAL_SUM_BW-1:0]   psum_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ARRAY_N*PARTIAL_SUM_BW-1:0]   out_data,
  output logic [CNT_BW-1:0]                   row_cnt,
  output logic                                ovf_err
);

  localparam int                ROW_BW  = ARRAY_N * PARTIAL_SUM_BW;
  localparam int                FIFO_CW = clog2_int(FIFO_DEPTH) + 1;
  localparam logic [CNT_BW-1:0] CNT_ONE = CNT_BW'(1);

  logic [ARRAY_N-2:0]  vld_pipe;
  logic [ROW_BW-1:0]   aligned_row;
  logic [ROW_BW-1:0]   fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FIFO_CW-1:0]  fifo_count;
  logic                fifo_drop;
  logic                row_wr;
  logic                pop;

  // Lane k arrives k cycles after lane 0, so it waits ARRAY_N-1-k cycles to
  // line up with the last lane, which is taken straight from the input.
  for (genvar k = 0; k < ARRAY_N; k++) begin : g_lane
    localparam int DLY = ARRAY_N - 1 - k;
    if (DLY == 0) begin : g_comb
      assign aligned_row[k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] =
        psum_in[k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
    end else begin : g_dly
      logic [PARTIAL_SUM_BW-1:0] dly [DLY];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DLY; i++) dly[i] <= '0;
        end else begin
          dly[0] <= psum_in[k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
          for (int i = 1; i < DLY; i++) dly[i] <= dly[i-1];
        end
      end
      assign aligned_row[k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = dly[DLY-1];
    end
  end

  // Row-valid travels with the slowest lane (lane 0); clearing it is enough to
  // discard rows mid-deskew, the data delay lines may keep stale values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (clear) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_valid;
      for (int i = 1; i < ARRAY_N - 1; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign row_wr = vld_pipe[ARRAY_N-2];

  psum_row_fifo #(
    .WIDTH (ROW_BW),
    .DEPTH (FIFO_DEPTH),
    .CW    (FIFO_CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .wr_en   (row_wr),
    .wr_data (aligned_row),
    .rd_en   (out_ready),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .drop    (fifo_drop)
  );

  // No bypass: a row written this cycle is first visible next cycle.
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_head : '0;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= '0;
      ovf_err <= 1'b0;
    end else if (clear) begin
      row_cnt <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (pop)       row_cnt <= row_cnt + CNT_ONE;
      if (fifo_drop) ovf_err <= 1'b1;
    end
  end

  // Occupancy bookkeeping must agree with the flags the datapath relies on.
  always @(posedge clk) begin
    if (!rst) begin
      assert (fifo_empty == (fifo_count == '0));
      assert (fifo_full || (fifo_count < FIFO_CW'(FIFO_DEPTH)));
    end
  end

endmodule

// File: tb/tb_psum_deskew_collector.sv
module tb_psum_deskew_collector;
  import sysarr_pkg::*;

  localparam int N     = 8;
  localparam int BW    = 19;
  localparam int W     = N * BW;
  localparam int DEPTH = 4;
  localparam int CBW   = 16;

  typedef struct {
    int           t;
    logic [W-1:0] data;
  } ent_t;

  // ---------------- clock / reset ----------------
  logic           clk;
  logic           rst;
  logic           clear;
  logic           in_valid;
  logic [W-1:0]   psum_in;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [CBW-1:0] row_cnt;
  logic           ovf_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  psum_deskew_collector #(
    .ARRAY_N        (N),
    .PARTIAL_SUM_BW (BW),
    .FIFO_DEPTH     (DEPTH),
    .CNT_BW         (CBW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .psum_in   (psum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .row_cnt   (row_cnt),
    .ovf_err   (ovf_err)
  );

  // ---------------- reference model state ----------------
  // A row launched at cycle t lands in the buffer at the end of cycle t+N-1;
  // the buffer is a plain queue of at most DEPTH rows.
  int             cyc;
  int             cmp_cnt;
  int             fail_cnt;
  ent_t           launch_q[$];
  ent_t           pend_q[$];
  logic [W-1:0]   exp_q[$];
  logic [CBW-1:0] exp_cnt;
  logic           exp_ovf;

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      fail_cnt++;
      $error("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] ed;
    logic         ev;
    ev = (exp_q.size() > 0);
    ed = ev ? exp_q[0] : '0;
    chk({tag, ".out_valid"}, W'(out_valid), W'(ev));
    chk({tag, ".out_data"},  out_data, ed);
    chk({tag, ".row_cnt"},   W'(row_cnt), W'(exp_cnt));
    chk({tag, ".ovf_err"},   W'(ovf_err), W'(exp_ovf));
  endtask

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0]  v;
    logic [31:0]   r;
    for (int k = 0; k < N; k++) begin
      r = $urandom;
      v[k*BW +: BW] = r[BW-1:0];
    end
    return v;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input string tag, input logic iv, input logic [W-1:0] row,
                      input logic rdy, input logic clr);
    logic [W-1:0] vec;
    logic         was_full;
    logic         popped;
    // skewed drive: lane k carries the row launched k cycles ago, noise otherwise
    if (iv) launch_q.push_back('{cyc, row});
    while (launch_q.size() > 0 && launch_q[0].t < cyc - (N - 1)) void'(launch_q.pop_front());
    vec = rand_row();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < launch_q.size(); j++)
        if (launch_q[j].t == cyc - k) vec[k*BW +: BW] = psum_lane(launch_q[j].data, k);
    in_valid  = iv;
    psum_in   = vec;
    out_ready = rdy;
    clear     = clr;
    // model update to the state after this edge
    if (clr) begin
      exp_q.delete();
      pend_q.delete();
      exp_cnt = '0;
      exp_ovf = 1'b0;
    end else begin
      was_full = (exp_q.size() == DEPTH);
      popped   = (exp_q.size() > 0) && rdy;
      if (popped) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
      if (pend_q.size() > 0 && pend_q[0].t == cyc) begin
        if (was_full && !popped) exp_ovf = 1'b1;
        else exp_q.push_back(pend_q[0].data);
        void'(pend_q.pop_front());
      end
      if (iv) pend_q.push_back('{cyc + N - 1, row});
    end
    @(posedge clk);
    #1;
    cyc++;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, rdy, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] row;
    cmp_cnt   = 0;
    fail_cnt  = 0;
    cyc       = 0;
    exp_cnt   = '0;
    exp_ovf   = 1'b0;
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    psum_in   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("reset");

    // 1: single row, lane k = k+1
    for (int k = 0; k < N; k++) row[k*BW +: BW] = BW'(k + 1);
    step("t1", 1'b1, row, 1'b1, 1'b0);
    idle("t1", 6, 1'b1);
    chk("t1.no_early_valid", W'(out_valid), W'(1'b0));
    idle("t1", 1, 1'b1);
    chk("t1.valid_at_t8", W'(out_valid), W'(1'b1));
    chk("t1.lanes", out_data, row);
    idle("t1", 2, 1'b1);
    chk("t1.row_cnt", W'(row_cnt), W'(1));

    // 2: most-negative values keep their sign bit-exact
    for (int k = 0; k < N; k++) row[k*BW +: BW] = BW'(19'h40000 + k);
    step("t2", 1'b1, row, 1'b1, 1'b0);
    idle("t2", 7, 1'b1);
    chk("t2.neg_lanes", out_data, row);
    idle("t2", 2, 1'b1);

    // 3: 8 back-to-back rows, consumer always ready
    for (int i = 0; i < 8; i++) step("t3", 1'b1, rand_row(), 1'b1, 1'b0);
    idle("t3", 12, 1'b1);
    chk("t3.row_cnt", W'(row_cnt), W'(10));

    // 4: stalled consumer, fifth row is dropped, then drain in order
    for (int i = 0; i < 5; i++) step("t4", 1'b1, rand_row(), 1'b0, 1'b0);
    idle("t4", 10, 1'b0);
    chk("t4.ovf_sticky", W'(ovf_err), W'(1'b1));
    idle("t4", 6, 1'b1);
    chk("t4.drained", W'(out_valid), W'(1'b0));

    // 5: full FIFO, pop and new row in the same cycle -> no drop
    step("t5", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("t5", 1'b1, rand_row(), 1'b0, 1'b0);
    step("t5", 1'b1, rand_row(), 1'b0, 1'b0);
    idle("t5", 6, 1'b0);
    idle("t5", 1, 1'b1);
    idle("t5", 3, 1'b0);
    chk("t5.no_ovf", W'(ovf_err), W'(1'b0));
    idle("t5", 6, 1'b1);

    // 6a: clear while a row is mid-deskew
    step("t6a", 1'b1, rand_row(), 1'b1, 1'b0);
    idle("t6a", 2, 1'b1);
    step("t6a", 1'b0, '0, 1'b1, 1'b1);
    idle("t6a", 10, 1'b1);
    chk("t6a.row_cnt_cleared", W'(row_cnt), W'(0));

    // 6b: asynchronous reset while a row is being offered
    step("t6b", 1'b1, rand_row(), 1'b0, 1'b0);
    idle("t6b", 7, 1'b0);
    chk("t6b.valid_before_rst", W'(out_valid), W'(1'b1));
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("t6b.rst_valid", W'(out_valid), W'(1'b0));
    chk("t6b.rst_data",  out_data, '0);
    chk("t6b.rst_cnt",   W'(row_cnt), W'(0));
    chk("t6b.rst_ovf",   W'(ovf_err), W'(1'b0));
    exp_q.delete();
    pend_q.delete();
    launch_q.delete();
    exp_cnt = '0;
    exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    check_all("t6b.after_rst");

    // random traffic: slow consumer first to provoke overflow, then fast
    for (int i = 0; i < 300; i++) begin
      logic iv;
      logic rdy;
      logic clr;
      iv  = ($urandom_range(0, 2) != 0);
      rdy = (i < 150) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 63) == 0);
      step("rnd", iv, rand_row(), rdy, clr);
    end
    idle("final", 14, 1'b1);
    chk("final.empty", W'(out_valid), W'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
